// File: rtl/l2_resp_pkg.sv
// Shared types and constants for the L2 memory responder.
package l2_resp_pkg;

   // Responder FSM: sample a request, count out the latency, pulse the grant.
   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } l2_resp_state_t;

   // One bit identifies which L1 client owns the current access.
   typedef logic l2_client_id_t;

   localparam l2_client_id_t CLIENT_ICACHE = 1'b0;
   localparam l2_client_id_t CLIENT_DCACHE = 1'b1;

endpackage

// File: rtl/l2_backing_sram.sv
// Word-addressed backing store: one port, synchronous write, combinational read.
module l2_backing_sram #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] memArray [2**AW];

   // Storage is deliberately not reset; contents survive a responder reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         memArray[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = memArray[addr_i];

endmodule

// File: rtl/l2_mem_responder.sv
// L2-side responder for the instruction (client 0) and data (client 1) L1 caches.
// Round-robin arbitration, one word access at a time, one-cycle grant pulses.
module l2_mem_responder
   import l2_resp_pkg::*;
#(
   parameter int MEM_AW     = 12,
   parameter int RD_LATENCY = 2,
   parameter int WR_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c0_mem_en,
   input  logic        c0_mem_wr_en,
   input  logic [31:0] c0_access_addr,
   input  logic [31:0] c0_wr_data,
   output logic [31:0] c0_rd_data,
   output logic        c0_rd_granted,
   output logic        c0_wr_granted,
   input  logic        c1_mem_en,
   input  logic        c1_mem_wr_en,
   input  logic [31:0] c1_access_addr,
   input  logic [31:0] c1_wr_data,
   output logic [31:0] c1_rd_data,
   output logic        c1_rd_granted,
   output logic        c1_wr_granted,
   output logic        busy
);

   localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(RD_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WR_LATENCY - 1);

   l2_resp_state_t    state_q, state_d;
   l2_client_id_t     rrPtr_q, rrPtr_d;
   l2_client_id_t     winner_q, winner_d;
   logic              isWrite_q, isWrite_d;
   logic [MEM_AW-1:0] wordIdx_q, wordIdx_d;
   logic [31:0]       wrData_q, wrData_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       c0RdData_q, c0RdData_d;
   logic [31:0]       c1RdData_q, c1RdData_d;
   logic [1:0]        rdGrant_q, rdGrant_d;
   logic [1:0]        wrGrant_q, wrGrant_d;

   l2_client_id_t     pickId;
   logic              pickWr;
   logic [MEM_AW-1:0] pickIdx;
   logic [31:0]       pickData;

   logic              sramWe;
   logic [31:0]       sramRdata;

   // Byte offset and address bits beyond the store size carry no meaning here.
   logic              unusedAddrBits;
   assign unusedAddrBits = ^{c0_access_addr[31:MEM_AW+2], c0_access_addr[1:0],
                             c1_access_addr[31:MEM_AW+2], c1_access_addr[1:0]};

   l2_backing_sram #(
      .AW(MEM_AW)
   ) u_sram (
      .clk     (clk),
      .we_i    (sramWe),
      .addr_i  (wordIdx_q),
      .wdata_i (wrData_q),
      .rdata_o (sramRdata)
   );

   // Pick the requesting client; on a tie the round-robin pointer decides.
   always_comb begin
      pickId = CLIENT_ICACHE;
      if (c0_mem_en && c1_mem_en) begin
         pickId = rrPtr_q;
      end else if (c1_mem_en) begin
         pickId = CLIENT_DCACHE;
      end
      pickWr   = c0_mem_wr_en;
      pickIdx  = c0_access_addr[MEM_AW+1:2];
      pickData = c0_wr_data;
      if (pickId == CLIENT_DCACHE) begin
         pickWr   = c1_mem_wr_en;
         pickIdx  = c1_access_addr[MEM_AW+1:2];
         pickData = c1_wr_data;
      end
   end

   // Next-state logic: latch the winner, count out its latency, then commit and grant.
   always_comb begin
      state_d    = state_q;
      rrPtr_d    = rrPtr_q;
      winner_d   = winner_q;
      isWrite_d  = isWrite_q;
      wordIdx_d  = wordIdx_q;
      wrData_d   = wrData_q;
      cnt_d      = cnt_q;
      c0RdData_d = c0RdData_q;
      c1RdData_d = c1RdData_q;
      rdGrant_d  = 2'b00;
      wrGrant_d  = 2'b00;
      sramWe     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (c0_mem_en || c1_mem_en) begin
               winner_d  = pickId;
               isWrite_d = pickWr;
               wordIdx_d = pickIdx;
               wrData_d  = pickData;
               cnt_d     = pickWr ? WR_CNT_INIT : RD_CNT_INIT;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               if (isWrite_q) begin
                  sramWe              = 1'b1;
                  wrGrant_d[winner_q] = 1'b1;
               end else begin
                  rdGrant_d[winner_q] = 1'b1;
                  if (winner_q == CLIENT_DCACHE) begin
                     c1RdData_d = sramRdata;
                  end else begin
                     c0RdData_d = sramRdata;
                  end
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            rrPtr_d = ~winner_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rrPtr_q    <= CLIENT_ICACHE;
         winner_q   <= CLIENT_ICACHE;
         isWrite_q  <= 1'b0;
         wordIdx_q  <= '0;
         wrData_q   <= '0;
         cnt_q      <= '0;
         c0RdData_q <= '0;
         c1RdData_q <= '0;
         rdGrant_q  <= 2'b00;
         wrGrant_q  <= 2'b00;
      end else begin
         state_q    <= state_d;
         rrPtr_q    <= rrPtr_d;
         winner_q   <= winner_d;
         isWrite_q  <= isWrite_d;
         wordIdx_q  <= wordIdx_d;
         wrData_q   <= wrData_d;
         cnt_q      <= cnt_d;
         c0RdData_q <= c0RdData_d;
         c1RdData_q <= c1RdData_d;
         rdGrant_q  <= rdGrant_d;
         wrGrant_q  <= wrGrant_d;
      end
   end

   assign c0_rd_data    = c0RdData_q;
   assign c1_rd_data    = c1RdData_q;
   assign c0_rd_granted = rdGrant_q[CLIENT_ICACHE];
   assign c0_wr_granted = wrGrant_q[CLIENT_ICACHE];
   assign c1_rd_granted = rdGrant_q[CLIENT_DCACHE];
   assign c1_wr_granted = wrGrant_q[CLIENT_DCACHE];
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed scoreboard bench for the L2 memory responder.
module tb_l2_mem_responder;

   localparam int RD_LAT = 2;
   localparam int WR_LAT = 1;

   logic        clk;
   logic        rst_n;
   logic        c0_mem_en, c0_mem_wr_en, c1_mem_en, c1_mem_wr_en;
   logic [31:0] c0_access_addr, c0_wr_data, c1_access_addr, c1_wr_data;
   logic [31:0] c0_rd_data, c1_rd_data;
   logic        c0_rd_granted, c0_wr_granted, c1_rd_granted, c1_wr_granted;
   logic        busy;

   typedef struct {
      logic        client;
      logic        isWrite;
      logic [31:0] data;
   } sbEntry_t;

   sbEntry_t    sbQ [$];
   logic [31:0] model [int];
   logic [31:0] lastRd [2];
   int          checks;
   int          errors;

   l2_mem_responder #(
      .MEM_AW     (12),
      .RD_LATENCY (RD_LAT),
      .WR_LATENCY (WR_LAT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .c0_mem_en      (c0_mem_en),
      .c0_mem_wr_en   (c0_mem_wr_en),
      .c0_access_addr (c0_access_addr),
      .c0_wr_data     (c0_wr_data),
      .c0_rd_data     (c0_rd_data),
      .c0_rd_granted  (c0_rd_granted),
      .c0_wr_granted  (c0_wr_granted),
      .c1_mem_en      (c1_mem_en),
      .c1_mem_wr_en   (c1_mem_wr_en),
      .c1_access_addr (c1_access_addr),
      .c1_wr_data     (c1_wr_data),
      .c1_rd_data     (c1_rd_data),
      .c1_rd_granted  (c1_rd_granted),
      .c1_wr_granted  (c1_wr_granted),
      .busy           (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one request and record what the responder should hand back for it.
   task automatic applyStimulus(input logic client, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data);
      sbEntry_t e;
      int       idx;
      idx       = int'((addr >> 2) & 32'h0000_0FFF);
      e.client  = client;
      e.isWrite = wr;
      if (wr) begin
         e.data     = data;
         model[idx] = data;
      end else begin
         e.data = model.exists(idx) ? model[idx] : 32'h0;
      end
      sbQ.push_back(e);
      if (client) begin
         c1_mem_en = 1'b1; c1_mem_wr_en = wr; c1_access_addr = addr; c1_wr_data = data;
      end else begin
         c0_mem_en = 1'b1; c0_mem_wr_en = wr; c0_access_addr = addr; c0_wr_data = data;
      end
   endtask

   // Wait for the next grant, check its timing against the scoreboard head, release the request.
   task automatic checkOutput(input int expCycles, input string tag);
      int          n;
      logic        got;
      logic [3:0]  g;
      logic        gClient, gWr;
      logic [31:0] gData;
      sbEntry_t    e;
      n   = 0;
      got = 1'b0;
      g   = 4'b0000;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         g = {c1_wr_granted, c1_rd_granted, c0_wr_granted, c0_rd_granted};
         checkVal({tag, "_onehot"}, 32'($countones(g) <= 1), 32'd1);
         got = |g;
      end
      checkVal({tag, "_latency"}, 32'(n), 32'(expCycles));
      if (got) begin
         gClient = g[3] | g[2];
         gWr     = g[3] | g[1];
         checkVal({tag, "_sbhas"}, 32'(sbQ.size() > 0), 32'd1);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkVal({tag, "_client"}, 32'(gClient), 32'(e.client));
            checkVal({tag, "_op"}, 32'(gWr), 32'(e.isWrite));
            if (!e.isWrite) begin
               gData = gClient ? c1_rd_data : c0_rd_data;
               checkVal({tag, "_rdata"}, gData, e.data);
               lastRd[gClient] = e.data;
            end
            checkVal({tag, "_otherdata"}, gClient ? c0_rd_data : c1_rd_data, lastRd[!gClient]);
         end
         if (gClient) begin
            c1_mem_en = 1'b0; c1_mem_wr_en = 1'b0;
         end else begin
            c0_mem_en = 1'b0; c0_mem_wr_en = 1'b0;
         end
      end
   endtask

   task automatic idleCycle();
      @(negedge clk);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      c0_mem_en = 1'b0; c0_mem_wr_en = 1'b0; c0_access_addr = '0; c0_wr_data = '0;
      c1_mem_en = 1'b0; c1_mem_wr_en = 1'b0; c1_access_addr = '0; c1_wr_data = '0;
      repeat (2) @(negedge clk);
      checkVal("rst_busy", 32'(busy), 32'd0);
      checkVal("rst_grants", 32'({c1_wr_granted, c1_rd_granted, c0_wr_granted, c0_rd_granted}), 32'd0);
      checkVal("rst_c0data", c0_rd_data, 32'h0);
      checkVal("rst_c1data", c1_rd_data, 32'h0);
      lastRd[0] = 32'h0;
      lastRd[1] = 32'h0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Directed sequence covering single access, write/read, wrap, line fill, contention, reset.
   initial begin
      checks = 0;
      errors = 0;
      $display("[TB] start");
      doReset();

      // Single read by the data client after seeding the word via the instruction client.
      applyStimulus(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
      checkOutput(WR_LAT + 1, "seed40");
      idleCycle();
      applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
      checkOutput(RD_LAT + 1, "t1_read");
      idleCycle();

      // Write then read the same word.
      applyStimulus(1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D);
      checkOutput(WR_LAT + 1, "t2_write");
      idleCycle();
      applyStimulus(1'b1, 1'b0, 32'h0000_0080, 32'h0);
      checkOutput(RD_LAT + 1, "t2_read");
      idleCycle();

      // Address wrap: 0x4000 aliases word 0 in a 4K-word store.
      applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D);
      checkOutput(WR_LAT + 1, "t5_seed0");
      idleCycle();
      applyStimulus(1'b1, 1'b0, 32'h0000_4000, 32'h0);
      checkOutput(RD_LAT + 1, "t5_wrap");
      idleCycle();

      // Four-word line fill, issued back to back by the data client.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 32'h0000_0100 + 32'(i * 4), 32'hA5A5_0000 + 32'(i * 17));
         checkOutput(WR_LAT + 1, "t4_seed");
         idleCycle();
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0);
         checkOutput((i == 0) ? RD_LAT + 1 : RD_LAT + 2, "t4_fill");
      end
      idleCycle();

      // Write-enable without request enable must be ignored.
      c0_mem_en = 1'b0; c0_mem_wr_en = 1'b1; c0_access_addr = 32'h0; c0_wr_data = 32'hFFFF_FFFF;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkVal("t5_noen_busy", 32'(busy), 32'd0);
         checkVal("t5_noen_grant", 32'({c1_wr_granted, c1_rd_granted, c0_wr_granted, c0_rd_granted}), 32'd0);
      end
      c0_mem_wr_en = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0000_0000, 32'h0);
      checkOutput(RD_LAT + 1, "t5_noen_read");
      idleCycle();

      // Contention right after reset: client 0 first, client 1 once it is released.
      doReset();
      applyStimulus(1'b0, 1'b0, 32'h0000_0040, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0080, 32'h0);
      checkOutput(RD_LAT + 1, "t3_c0");
      checkOutput(RD_LAT + 2, "t3_c1");
      idleCycle();

      // Reset during the wait cycle of a write: no grant and no store update.
      applyStimulus(1'b0, 1'b1, 32'h0000_0200, 32'h1111_1111);
      checkOutput(WR_LAT + 1, "t6_seed");
      idleCycle();
      c0_mem_en = 1'b1; c0_mem_wr_en = 1'b1; c0_access_addr = 32'h0000_0200; c0_wr_data = 32'h2222_2222;
      @(posedge clk);
      #1;
      checkVal("t6_busy_wait", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      checkVal("t6_busy_rst", 32'(busy), 32'd0);
      checkVal("t6_grant_rst", 32'({c1_wr_granted, c1_rd_granted, c0_wr_granted, c0_rd_granted}), 32'd0);
      @(negedge clk);
      c0_mem_en = 1'b0; c0_mem_wr_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      lastRd[0] = 32'h0;
      lastRd[1] = 32'h0;
      idleCycle();
      applyStimulus(1'b0, 1'b0, 32'h0000_0200, 32'h0);
      checkOutput(RD_LAT + 1, "t6_read");
      idleCycle();

      checkVal("sb_drained", 32'(sbQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
